// File: rtl/sram_ctrl.sv
// Multi-cycle SRAM controller: splits each 32-bit access into two
// 16-bit half-word cycles and freezes the pipeline until it finishes.
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        freeze,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {
    IDLE, LOW, HIGH, DONE
  } state_e;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [16:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req;
  logic        last;
  logic        unused;

  assign req    = mem_r_en | mem_w_en;
  assign last   = (cnt_q == LAST);
  assign unused = ^{address[31:19], address[1:0]};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LOW;
          cnt_d   = '0;
          wr_d    = mem_w_en;
          addr_d  = address[18:2];
          wdata_d = write_data;
        end
      end
      LOW: begin
        if (last) begin
          state_d = HIGH;
          cnt_d   = '0;
          if (!wr_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!wr_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    unique case (state_q)
      LOW, HIGH: begin
        sram_addr = {addr_q, state_q == HIGH};
        if (wr_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = (state_q == HIGH) ? wdata_q[31:16]
                                          : wdata_q[15:0];
        end
      end
      DONE: ready = 1'b1;
      default: ;
    endcase
  end

  assign read_data = rdata_q;
  assign freeze    = req & ~ready;

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, SRAM cycles spent on each 16-bit half-word access; legal range 1..15.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clock edge.
REQ-004 mem_r_en  input  1  MEM-stage load request.
REQ-005 mem_w_en  input  1  MEM-stage store request.
REQ-006 address  input  32  byte address from ALU result; only bits [18:2] used.
REQ-007 write_data  input  32  store data.
REQ-008 read_data  output  32  load data; registered.
REQ-009 ready  output  1  one-cycle pulse, access complete.
REQ-010 freeze  output  1  stall to IF/ID/EX/MEM and MEM/WB pipeline registers.
REQ-011 sram_addr  output  18  half-word address to SRAM.
REQ-012 sram_dq_out  output  16  data driven to SRAM.
REQ-013 sram_dq_in  input  16  data returned from SRAM.
REQ-014 sram_dq_oe  output  1  1 = controller drives SRAM data bus.
REQ-015 sram_we_n  output  1  SRAM write enable, active-low.

Function
REQ-016 FSM states SHALL be IDLE, LOW, HIGH, DONE; a 4-bit wait counter counts cycles within LOW and HIGH.
REQ-017 IDLE: on mem_r_en|mem_w_en = 1, latch op (write if mem_w_en=1, else read), address[18:2], write_data; next state LOW, counter cleared.
REQ-018 Both mem_r_en and mem_w_en = 1 SHALL be treated as a write; the read is discarded.
REQ-019 LOW: stay WAIT_CYCLES cycles, sram_addr = {latched addr, 1'b0}; then HIGH, counter cleared.
REQ-020 HIGH: stay WAIT_CYCLES cycles, sram_addr = {latched addr, 1'b1}; then DONE.
REQ-021 DONE: ready = 1 for exactly one cycle; next state IDLE unconditionally.
REQ-022 Read: read_data[15:0] SHALL capture sram_dq_in on the last LOW cycle, read_data[31:16] on the last HIGH cycle; read_data holds until the next read overwrites it; writes never modify read_data.
REQ-023 Write: sram_we_n = 0 and sram_dq_oe = 1 in every LOW/HIGH cycle; sram_dq_out = write_data[15:0] in LOW, write_data[31:16] in HIGH.
REQ-024 Read or IDLE/DONE: sram_we_n = 1, sram_dq_oe = 0, sram_dq_out = 0.
REQ-025 sram_addr SHALL be 0 in IDLE and DONE.
REQ-026 freeze SHALL equal (mem_r_en | mem_w_en) & ~ready, combinational; freeze = 0 in DONE regardless of requests.
REQ-027 Latency: request seen in IDLE at cycle 0 -> ready at cycle 2*WAIT_CYCLES+1; freeze high cycles 0..2*WAIT_CYCLES.
REQ-028 Request deasserted mid-access: access SHALL complete and ready still pulse; no abort.
REQ-029 Request asserted in DONE SHALL be ignored; it is accepted the following IDLE cycle.
REQ-030 Request inputs changing mid-access SHALL NOT alter latched address, data or op.

Reset
REQ-031 reset = 0 at a clock edge: state IDLE, counter 0, read_data 0, ready 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1.
REQ-032 Reset mid-access (LOW/HIGH) SHALL abandon the access immediately; write strobe deasserted in the same edge; no ready pulse.
REQ-033 freeze during reset SHALL follow REQ-026 combinationally (ready = 0).

Verification
REQ-034 WAIT_CYCLES=2, write 0xDEADBEEF to address 0x0000_0010 -> sram_addr 0x00008 for 2 cycles with dq_out 0xBEEF, then 0x00009 for 2 cycles with 0xDEAD, we_n low 4 cycles, ready at cycle 5.
REQ-035 Read of address 0x10 with sram_dq_in = 0x1234 in LOW, 0xABCD in HIGH -> read_data = 0xABCD1234 at DONE, freeze high cycles 0..4, low at cycle 5.
REQ-036 mem_r_en and mem_w_en both high -> write cycle performed, read_data unchanged.
REQ-037 reset = 0 during HIGH of a write -> next cycle state IDLE, we_n = 1, dq_oe = 0, no ready pulse; new read afterward completes normally.
REQ-038 Back-to-back: read held through DONE then new request -> second access starts the cycle after DONE; ready pulses exactly once per access.
REQ-039 WAIT_CYCLES=1 and 15 -> ready at cycle 3 and 31 respectively.
